// File: rtl/alarm_pkg.sv
// alarm_pkg: shared definitions for the alarm controller.
//   - alarm_state_t : FSM state encoding, also the value driven on alarm_state
//   - BCD digit limits used by the HH:MM validity check
//   - ALARM_RESET_HHMM : alarm time after reset (07:00)
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZE   = 2'd3
  } alarm_state_t;

  localparam logic [3:0]  BCD_HR_TENS_MAX      = 4'd2;
  localparam logic [3:0]  BCD_HR_UNITS_MAX_20S = 4'd3;
  localparam logic [3:0]  BCD_MIN_TENS_MAX     = 4'd5;
  localparam logic [3:0]  BCD_DIGIT_MAX        = 4'd9;

  localparam logic [15:0] ALARM_RESET_HHMM     = 16'h0700;

endpackage

// File: rtl/bcd_hhmm_valid.sv
// bcd_hhmm_valid: combinational check that a 16-bit BCD word is a legal
// 24-hour HH:MM time (00:00 .. 23:59).
//   i_hhmm  : {hr tens, hr units, min tens, min units}, BCD
//   o_valid : 1 when every digit is in range
module bcd_hhmm_valid
  import alarm_pkg::*;
(
  input  logic [15:0] i_hhmm,
  output logic        o_valid
);

  logic [3:0] w_hr_t;
  logic [3:0] w_hr_u;
  logic [3:0] w_min_t;
  logic [3:0] w_min_u;
  logic       w_hr_ok;
  logic       w_min_ok;

  assign {w_hr_t, w_hr_u, w_min_t, w_min_u} = i_hhmm;

  // In the 20s the hour units digit may only reach 3.
  assign w_hr_ok = (w_hr_t < BCD_HR_TENS_MAX)  ? (w_hr_u <= BCD_DIGIT_MAX) :
                   (w_hr_t == BCD_HR_TENS_MAX) ? (w_hr_u <= BCD_HR_UNITS_MAX_20S) :
                   1'b0;

  assign w_min_ok = (w_min_t <= BCD_MIN_TENS_MAX) && (w_min_u <= BCD_DIGIT_MAX);

  assign o_valid = w_hr_ok && w_min_ok;

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: HH:MM alarm with arm / ring / snooze sequencing, fed by the
// BCD time-of-day counter once per clk_1Hz tick.
//
// Build option: define ALARM_SNOOZE_EN to include the SNOOZE state, snooze
// counter and snooze budget. Without it snooze_req is ignored and
// snooze_left reads 0.
//
// Ports
//   clk_1Hz, reset          : 1 Hz clock, async active-high reset
//   msb_hr .. lsb_sec       : current time, BCD digits
//   arm                     : level, 1 = alarm enabled
//   alarm_load, alarm_hhmm  : load strobe and BCD HH:MM to load
//   snooze_req, stop_req    : single-cycle user requests
//   ringing                 : buzzer/LED drive, high while RINGING
//   alarm_state             : current state (encoding below)
//   alarm_time              : stored alarm HH:MM, BCD
//   load_err                : pulse when a load is rejected
//   missed                  : pulse when a ring times out unattended
//   snooze_left             : snoozes remaining for the current ring event
//
// state       | meaning
// ------------+----------------------------------------------------
// DISARMED(0) | alarm off, waiting for arm
// ARMED(1)    | watching for HH:MM:00 == alarm_time
// RINGING(2)  | ringing; ring counter counts up to the timeout
// SNOOZE(3)   | silenced; snooze counter counts down to re-ring
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic        clk_1Hz,
  input  logic        reset,
  input  logic [3:0]  msb_hr,
  input  logic [3:0]  lsb_hr,
  input  logic [3:0]  msb_min,
  input  logic [3:0]  lsb_min,
  input  logic [3:0]  msb_sec,
  input  logic [3:0]  lsb_sec,
  input  logic        arm,
  input  logic        alarm_load,
  input  logic [15:0] alarm_hhmm,
  input  logic        snooze_req,
  input  logic        stop_req,
  output logic        ringing,
  output logic [1:0]  alarm_state,
  output logic [15:0] alarm_time,
  output logic        load_err,
  output logic        missed,
  output logic [1:0]  snooze_left
);

  localparam int CNT_MAX = (SNOOZE_SEC > RING_TIMEOUT_SEC) ? SNOOZE_SEC : RING_TIMEOUT_SEC;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] RING_LAST = CW'(RING_TIMEOUT_SEC - 1);

  alarm_state_t  r_state;
  alarm_state_t  w_state_nxt;
  logic [CW-1:0] r_ring_cnt;
  logic [CW-1:0] w_ring_cnt_nxt;
  logic [15:0]   r_alarm_time;
  logic          r_ringing;
  logic          r_load_err;
  logic          r_missed;
  logic          w_missed_nxt;
  logic          w_load_ok;
  logic          w_match;

`ifdef ALARM_SNOOZE_EN
  localparam logic [CW-1:0] SNZ_LAST = CW'(SNOOZE_SEC - 1);
  localparam logic [1:0]    SL_MAX   = 2'(MAX_SNOOZE);

  logic [CW-1:0] r_snz_cnt;
  logic [CW-1:0] w_snz_cnt_nxt;
  logic [1:0]    r_snooze_left;
  logic [1:0]    w_snooze_left_nxt;
`else
  logic          w_unused_snooze;
  assign w_unused_snooze = snooze_req | (MAX_SNOOZE == 0);
`endif

  bcd_hhmm_valid u_load_chk (
    .i_hhmm  (alarm_hhmm),
    .o_valid (w_load_ok)
  );

  // Compare against the stored alarm, not the one being loaded this cycle.
  assign w_match = ({msb_hr, lsb_hr, msb_min, lsb_min} == r_alarm_time) &&
                   (msb_sec == 4'd0) && (lsb_sec == 4'd0);

  always_comb begin
    w_state_nxt       = r_state;
    w_ring_cnt_nxt    = r_ring_cnt;
    w_missed_nxt      = 1'b0;
`ifdef ALARM_SNOOZE_EN
    w_snz_cnt_nxt     = r_snz_cnt;
    w_snooze_left_nxt = r_snooze_left;
`endif
    case (r_state)
      ST_DISARMED: begin
        if (arm) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (!arm) begin
          w_state_nxt = ST_DISARMED;
        end else if (w_match) begin
          w_state_nxt       = ST_RINGING;
          w_ring_cnt_nxt    = '0;
`ifdef ALARM_SNOOZE_EN
          w_snooze_left_nxt = SL_MAX;
`endif
        end
      end
      ST_RINGING: begin
        if (!arm) begin
          w_state_nxt = ST_DISARMED;
        end else if (stop_req) begin
          w_state_nxt = ST_ARMED;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze_req && (r_snooze_left != 2'd0)) begin
          w_state_nxt       = ST_SNOOZE;
          w_snooze_left_nxt = r_snooze_left - 2'd1;
          w_snz_cnt_nxt     = SNZ_LAST;
`endif
        end else if (r_ring_cnt == RING_LAST) begin
          w_state_nxt  = ST_ARMED;
          w_missed_nxt = 1'b1;
        end else begin
          w_ring_cnt_nxt = r_ring_cnt + CW'(1);
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (!arm) begin
          w_state_nxt = ST_DISARMED;
        end else if (stop_req) begin
          w_state_nxt = ST_ARMED;
        end else if (r_snz_cnt == '0) begin
          w_state_nxt    = ST_RINGING;
          w_ring_cnt_nxt = '0;
        end else begin
          w_snz_cnt_nxt = r_snz_cnt - CW'(1);
        end
      end
`endif
      default: begin
        w_state_nxt = ST_DISARMED;
      end
    endcase
  end

  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      r_state       <= ST_DISARMED;
      r_ring_cnt    <= '0;
      r_ringing     <= 1'b0;
      r_missed      <= 1'b0;
      r_load_err    <= 1'b0;
      r_alarm_time  <= ALARM_RESET_HHMM;
`ifdef ALARM_SNOOZE_EN
      r_snz_cnt     <= '0;
      r_snooze_left <= SL_MAX;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_ring_cnt    <= w_ring_cnt_nxt;
      // Registered from next-state so ringing lines up with alarm_state.
      r_ringing     <= (w_state_nxt == ST_RINGING);
      r_missed      <= w_missed_nxt;
      r_load_err    <= alarm_load && !w_load_ok;
      if (alarm_load && w_load_ok) r_alarm_time <= alarm_hhmm;
`ifdef ALARM_SNOOZE_EN
      r_snz_cnt     <= w_snz_cnt_nxt;
      r_snooze_left <= w_snooze_left_nxt;
`endif
    end
  end

  assign ringing     = r_ringing;
  assign alarm_state = r_state;
  assign alarm_time  = r_alarm_time;
  assign load_err    = r_load_err;
  assign missed      = r_missed;
`ifdef ALARM_SNOOZE_EN
  assign snooze_left = r_snooze_left;
`else
  assign snooze_left = 2'd0;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed + randomized bench for alarm_ctrl. A timestamp
// based reference model predicts every output; a negedge process compares
// DUT and model each cycle, and directed steps pin key values to literals.
// Honours ALARM_SNOOZE_EN the same way the design does.
module tb_alarm_ctrl;

  localparam int SNOOZE_SEC = 300;
  localparam int RING_SEC   = 60;
  localparam int MAXS       = 3;
`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_EN     = 1;
`else
  localparam int SNZ_EN     = 0;
`endif
  localparam int LEFT_RST   = SNZ_EN ? MAXS : 0;

  logic        clk_1Hz = 1'b0;
  logic        reset;
  logic [3:0]  msb_hr, lsb_hr, msb_min, lsb_min, msb_sec, lsb_sec;
  logic        arm, alarm_load, snooze_req, stop_req;
  logic [15:0] alarm_hhmm;
  logic        ringing, load_err, missed;
  logic [1:0]  alarm_state, snooze_left;
  logic [15:0] alarm_time;

  alarm_ctrl #(
    .SNOOZE_SEC       (SNOOZE_SEC),
    .RING_TIMEOUT_SEC (RING_SEC),
    .MAX_SNOOZE       (MAXS)
  ) dut (
    .clk_1Hz     (clk_1Hz),
    .reset       (reset),
    .msb_hr      (msb_hr),
    .lsb_hr      (lsb_hr),
    .msb_min     (msb_min),
    .lsb_min     (lsb_min),
    .msb_sec     (msb_sec),
    .lsb_sec     (lsb_sec),
    .arm         (arm),
    .alarm_load  (alarm_load),
    .alarm_hhmm  (alarm_hhmm),
    .snooze_req  (snooze_req),
    .stop_req    (stop_req),
    .ringing     (ringing),
    .alarm_state (alarm_state),
    .alarm_time  (alarm_time),
    .load_err    (load_err),
    .missed      (missed),
    .snooze_left (snooze_left)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          tod;           // seconds since midnight driven to the DUT
  int          m_st;          // 0 disarmed, 1 armed, 2 ringing, 3 snooze
  logic [15:0] m_alarm;
  int          m_left;
  bit          m_err, m_missed, m_match;
  longint      cyc = 0, ring_end = 0, snz_end = 0;

  function automatic bit hhmm_ok(input logic [15:0] v);
    int ht, hu, mt, mu;
    ht = int'(v[15:12]); hu = int'(v[11:8]); mt = int'(v[7:4]); mu = int'(v[3:0]);
    return (hu <= 9) && (mu <= 9) && (ht * 10 + hu < 24) && (mt * 10 + mu < 60);
  endfunction

  function automatic logic [15:0] to_bcd(input int hh, input int mm);
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  always @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      m_st = 0; m_alarm = 16'h0700; m_left = LEFT_RST; m_err = 0; m_missed = 0;
    end else begin
      cyc++;
      m_match  = ({msb_hr, lsb_hr, msb_min, lsb_min} == m_alarm) &&
                 msb_sec == 0 && lsb_sec == 0;
      m_missed = 0;
      m_err    = alarm_load && !hhmm_ok(alarm_hhmm);
      if (alarm_load && hhmm_ok(alarm_hhmm)) m_alarm = alarm_hhmm;
      if (m_st == 0) begin
        if (arm) m_st = 1;
      end else if (!arm) begin
        m_st = 0;
      end else if (m_st == 1) begin
        if (m_match) begin
          m_st = 2; ring_end = cyc + RING_SEC; m_left = LEFT_RST;
        end
      end else if (stop_req) begin
        m_st = 1;
      end else if (m_st == 2) begin
        if (SNZ_EN != 0 && snooze_req && m_left > 0) begin
          m_st = 3; m_left--; snz_end = cyc + SNOOZE_SEC;
        end else if (cyc == ring_end) begin
          m_st = 1; m_missed = 1;
        end
      end else if (cyc == snz_end) begin
        m_st = 2; ring_end = cyc + RING_SEC;
      end
    end
  end

  always @(negedge clk_1Hz) begin
    check("ringing",     32'(ringing),     32'(m_st == 2));
    check("alarm_state", 32'(alarm_state), 32'(m_st));
    check("alarm_time",  32'(alarm_time),  32'(m_alarm));
    check("load_err",    32'(load_err),    32'(m_err));
    check("missed",      32'(missed),      32'(m_missed));
    check("snooze_left", 32'(snooze_left), 32'(m_left));
  end

  // ---------------- stimulus ----------------
  task automatic drive_tod();
    int h, m, s;
    h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
    msb_hr  = 4'(h / 10); lsb_hr  = 4'(h % 10);
    msb_min = 4'(m / 10); lsb_min = 4'(m % 10);
    msb_sec = 4'(s / 10); lsb_sec = 4'(s % 10);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      drive_tod();
      @(posedge clk_1Hz);
      #1;
      alarm_load = 1'b0; snooze_req = 1'b0; stop_req = 1'b0;
      tod = (tod + 1) % 86400;
    end
  endtask

  task automatic load(input logic [15:0] v);
    alarm_load = 1'b1; alarm_hhmm = v;
    tick(1);
  endtask

  // Load hh:mm and run the clock through hh:mm:00.
  task automatic ring_at(input int hh, input int mm);
    load(to_bcd(hh, mm));
    tod = (hh * 3600 + mm * 60 + 86400 - 1) % 86400;
    tick(2);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_ringing",  32'(ringing),     32'd0);
    check("rst_state",    32'(alarm_state), 32'd0);
    check("rst_time",     32'(alarm_time),  32'h0700);
    check("rst_left",     32'(snooze_left), 32'(LEFT_RST));
    check("rst_missed",   32'(missed),      32'd0);
    @(posedge clk_1Hz);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, m;
    reset = 1'b0; arm = 1'b0; alarm_load = 1'b0; alarm_hhmm = 16'h0;
    snooze_req = 1'b0; stop_req = 1'b0;
    tod = 12 * 3600;
    drive_tod();
    #1 reset = 1'b1;
    #12 reset = 1'b0;
    check("reset_time",  32'(alarm_time),  32'h0700);
    check("reset_state", 32'(alarm_state), 32'd0);
    check("reset_ring",  32'(ringing),     32'd0);
    check("reset_left",  32'(snooze_left), 32'(LEFT_RST));
    tick(2);

    // first ring at 06:30, unattended
    load(16'h0630);
    check("load_0630", 32'(alarm_time), 32'h0630);
    check("load_0630_err", 32'(load_err), 32'd0);
    arm = 1'b1;
    tick(1);
    check("armed", 32'(alarm_state), 32'd1);
    tod = 6 * 3600 + 29 * 60 + 59;
    tick(1);
    check("pre_match_ring", 32'(ringing), 32'd0);
    tick(1);
    check("match_ring",  32'(ringing),     32'd1);
    check("match_state", 32'(alarm_state), 32'd2);
    check("model_state", 32'(m_st),        32'd2);
    tick(RING_SEC - 1);
    check("ring_last_cycle", 32'(ringing), 32'd1);
    tick(1);
    check("timeout_ring",   32'(ringing),     32'd0);
    check("timeout_missed", 32'(missed),      32'd1);
    check("timeout_state",  32'(alarm_state), 32'd1);
    tick(1);
    check("missed_once", 32'(missed), 32'd0);

    // load validation
    load(16'h2400);
    check("bad_load_err",  32'(load_err),   32'd1);
    check("bad_load_keep", 32'(alarm_time), 32'h0630);
    tick(1);
    check("err_pulse_end", 32'(load_err), 32'd0);
    load(16'h2359);
    check("load_2359",     32'(alarm_time), 32'h2359);
    check("load_2359_err", 32'(load_err),   32'd0);

    // midnight alarm across the day wrap
    load(16'h0000);
    tod = 86399;
    tick(1);
    check("wrap_pre", 32'(alarm_state), 32'd1);
    tick(1);
    check("wrap_ring", 32'(ringing), 32'd1);

`ifdef ALARM_SNOOZE_EN
    tick(3);
    for (int s = 0; s < MAXS; s++) begin
      snooze_req = 1'b1;
      tick(1);
      check("snz_state", 32'(alarm_state), 32'd3);
      check("snz_left",  32'(snooze_left), 32'(MAXS - 1 - s));
      tick(SNOOZE_SEC - 1);
      check("snz_quiet", 32'(ringing), 32'd0);
      tick(1);
      check("snz_wake", 32'(ringing), 32'd1);
    end
    snooze_req = 1'b1;
    tick(1);
    check("snz_exhausted_state", 32'(alarm_state), 32'd2);
    check("snz_exhausted_left",  32'(snooze_left), 32'd0);
`else
    snooze_req = 1'b1;
    tick(1);
    check("nosnz_state", 32'(alarm_state), 32'd2);
    check("nosnz_left",  32'(snooze_left), 32'd0);
`endif
    stop_req = 1'b1;
    tick(1);
    check("stop_state", 32'(alarm_state), 32'd1);

    // coincident requests
    ring_at(8, 15);
    stop_req = 1'b1; snooze_req = 1'b1; arm = 1'b0;
    tick(1);
    check("prio_disarm", 32'(alarm_state), 32'd0);
    arm = 1'b1;
    tick(1);
    ring_at(8, 20);
    check("prio_ringing", 32'(alarm_state), 32'd2);
    stop_req = 1'b1; snooze_req = 1'b1;
    tick(1);
    check("prio_stop", 32'(alarm_state), 32'd1);

`ifdef ALARM_SNOOZE_EN
    ring_at(9, 10);
    snooze_req = 1'b1;
    tick(11);
    check("pre_reset_snz", 32'(alarm_state), 32'd3);
    pulse_reset();
`endif
    ring_at(9, 20);
    tick(1);
    ring_at(9, 30);
    tick(5);
    pulse_reset();

    // randomized phase
    arm = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) arm = ~arm;
      if ($urandom_range(0, 59) == 0) begin
        alarm_load = 1'b1;
        if ($urandom_range(0, 1) == 0)
          alarm_hhmm = to_bcd($urandom_range(0, 23), $urandom_range(0, 59));
        else
          alarm_hhmm = 16'($urandom);
      end
      snooze_req = ($urandom_range(0, 39) == 0);
      stop_req   = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 119) == 0) begin
        h = int'(m_alarm[15:12]) * 10 + int'(m_alarm[11:8]);
        m = int'(m_alarm[7:4]) * 10 + int'(m_alarm[3:0]);
        tod = (h * 3600 + m * 60 + 86400 - $urandom_range(1, 3)) % 86400;
      end
      tick(1);
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b1;
        @(posedge clk_1Hz);
        #1 reset = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
